// File: rtl/banco_registradores_pkg.sv
// Shared widths and well-known register indices for the MIPS register file.
package banco_registradores_pkg;

    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    localparam logic [ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [ADDR_W-1:0] REG_RA   = 5'd31;

endpackage

// File: rtl/banco_read_port.sv
// One read port: forces $zero to 0 and optionally forwards the in-flight write.
module banco_read_port #(
    parameter int DATA_W = banco_registradores_pkg::DATA_W,
    parameter int ADDR_W = banco_registradores_pkg::ADDR_W,
    parameter bit BYPASS = 1'b0
) (
    input  logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] reg_val,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [DATA_W-1:0] rd_data
);
    import banco_registradores_pkg::*;

    logic fwd;

    always_comb begin
        fwd = BYPASS && wr_en && (wr_addr != ADDR_W'(REG_ZERO))
              && (wr_addr == rd_addr);
        rd_data = reg_val;
        if (rd_addr == ADDR_W'(REG_ZERO)) begin
            rd_data = '0;
        end else if (fwd) begin
            rd_data = wr_data;
        end
    end

endmodule

// File: rtl/banco_registradores.sv
// MIPS 32x32 register file: two read ports, one debug port, one synchronous write.
module banco_registradores #(
    parameter int DATA_W = banco_registradores_pkg::DATA_W,
    parameter int ADDR_W = banco_registradores_pkg::ADDR_W,
    parameter bit BYPASS = 1'b0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic [ADDR_W-1:0] rd_addr2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic [ADDR_W-1:0] dbg_addr,
    output logic [DATA_W-1:0] dbg_data
);
    import banco_registradores_pkg::*;

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_q [DEPTH];
    logic [DATA_W-1:0] regs_d [DEPTH];

    always_comb begin
        regs_d = regs_q;
        if (wr_en && (wr_addr != ADDR_W'(REG_ZERO))) begin
            regs_d[wr_addr] = wr_data;
        end
    end

    // Reset takes priority, so a write on the same edge is dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            regs_q <= '{default: '0};
        end else begin
            regs_q <= regs_d;
        end
    end

    banco_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_port1 (
        .rd_addr (rd_addr1),
        .reg_val (regs_q[rd_addr1]),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_data (rd_data1)
    );

    banco_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (BYPASS)
    ) u_port2 (
        .rd_addr (rd_addr2),
        .reg_val (regs_q[rd_addr2]),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_data (rd_data2)
    );

    banco_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .BYPASS (1'b0)
    ) u_dbg (
        .rd_addr (dbg_addr),
        .reg_val (regs_q[dbg_addr]),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .rd_data (dbg_data)
    );

endmodule

// File: tb/tb_banco_registradores.sv
// Bench for banco_registradores: one instance without bypass, one with bypass.
module tb_banco_registradores;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  rd_addr1, rd_addr2, wr_addr, dbg_addr;
    logic        wr_en;
    logic [31:0] wr_data;
    logic [31:0] r1_n, r2_n, dbg_n;
    logic [31:0] r1_b, r2_b, dbg_b;

    int checks = 0;
    int errors = 0;

    logic [31:0] mdl [32];
    bit          mdl_valid = 1'b0;

    always #5 clk = ~clk;

    banco_registradores #(.BYPASS(1'b0)) dut_n (
        .clk      (clk),
        .reset    (reset),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (r1_n),
        .rd_data2 (r2_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_n)
    );

    banco_registradores #(.BYPASS(1'b1)) dut_b (
        .clk      (clk),
        .reset    (reset),
        .rd_addr1 (rd_addr1),
        .rd_addr2 (rd_addr2),
        .rd_data1 (r1_b),
        .rd_data2 (r2_b),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_b)
    );

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%h want=%h t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] expect_rd(input logic [4:0] a,
                                              input bit byp);
        if (a == 5'd0) return 32'd0;
        if (byp && wr_en && wr_addr != 5'd0 && wr_addr == a) return wr_data;
        return mdl[a];
    endfunction

    // Architectural model: the register file as a plain array.
    always @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 32; i++) mdl[i] = 32'd0;
            mdl_valid = 1'b1;
        end else if (wr_en && wr_addr != 5'd0) begin
            mdl[wr_addr] = wr_data;
        end
    end

    always @(negedge clk) begin
        if (mdl_valid) begin
            chk("cmp_rd1_nobyp", r1_n,  expect_rd(rd_addr1, 1'b0));
            chk("cmp_rd2_nobyp", r2_n,  expect_rd(rd_addr2, 1'b0));
            chk("cmp_dbg_nobyp", dbg_n, expect_rd(dbg_addr, 1'b0));
            chk("cmp_rd1_byp",   r1_b,  expect_rd(rd_addr1, 1'b1));
            chk("cmp_rd2_byp",   r2_b,  expect_rd(rd_addr2, 1'b1));
            chk("cmp_dbg_byp",   dbg_b, expect_rd(dbg_addr, 1'b0));
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [31:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick();
        wr_en   = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        wr_en    = 1'b0;
        wr_addr  = 5'd0;
        wr_data  = 32'd0;
        rd_addr1 = 5'd0;
        rd_addr2 = 5'd0;
        dbg_addr = 5'd0;
        tick();
        reset = 1'b0;

        // Reset sweep
        for (int i = 0; i < 32; i++) begin
            dbg_addr = 5'(i);
            #1;
            chk("reset_dbg_n", dbg_n, 32'd0);
            chk("reset_dbg_b", dbg_b, 32'd0);
        end

        // Write then read; old value visible before the edge without bypass
        rd_addr1 = 5'd8;
        dbg_addr = 5'd8;
        wr_en    = 1'b1;
        wr_addr  = 5'd8;
        wr_data  = 32'hDEADBEEF;
        #2;
        chk("wr8_pre_nobyp", r1_n, 32'd0);
        chk("wr8_pre_byp", r1_b, 32'hDEADBEEF);
        chk("wr8_pre_dbg_byp", dbg_b, 32'd0);
        tick();
        wr_en = 1'b0;
        #1;
        chk("wr8_post_nobyp", r1_n, 32'hDEADBEEF);
        chk("wr8_post_byp", r1_b, 32'hDEADBEEF);

        // $zero ignores writes and is never bypassed
        rd_addr1 = 5'd0;
        wr_en    = 1'b1;
        wr_addr  = 5'd0;
        wr_data  = 32'hFFFFFFFF;
        #2;
        chk("zero_pre_byp", r1_b, 32'd0);
        tick();
        wr_en = 1'b0;
        dbg_addr = 5'd0;
        #1;
        chk("zero_post_nobyp", r1_n, 32'd0);
        chk("zero_post_dbg", dbg_n, 32'd0);

        // Dual read
        wr(5'd9, 32'h00000005);
        wr(5'd10, 32'hFFFFFFFB);
        rd_addr1 = 5'd9;
        rd_addr2 = 5'd10;
        #1;
        chk("dual_rd1", r1_n, 32'h00000005);
        chk("dual_rd2", r2_n, 32'hFFFFFFFB);
        rd_addr2 = 5'd9;
        #1;
        chk("same_rd1", r1_n, 32'h00000005);
        chk("same_rd2", r2_n, 32'h00000005);

        // Bypass vs no bypass
        wr(5'd4, 32'd1);
        rd_addr1 = 5'd4;
        rd_addr2 = 5'd4;
        wr_en    = 1'b1;
        wr_addr  = 5'd4;
        wr_data  = 32'd2;
        #2;
        chk("byp_pre_nobyp", r1_n, 32'd1);
        chk("byp_pre_byp1", r1_b, 32'd2);
        chk("byp_pre_byp2", r2_b, 32'd2);
        tick();
        wr_en = 1'b0;
        #1;
        chk("byp_post_nobyp", r1_n, 32'd2);
        chk("byp_post_byp", r1_b, 32'd2);

        // wr_en=0 leaves state alone
        wr_addr = 5'd4;
        wr_data = 32'hCAFEF00D;
        tick();
        chk("noen_hold", r1_n, 32'd2);

        // Fill every register and spot-check through the model
        for (int i = 1; i < 32; i++) begin
            rd_addr1 = 5'(i);
            rd_addr2 = 5'(32 - i);
            dbg_addr = 5'(i - 1);
            wr(5'(i), 32'h01010101 * i ^ 32'hA5000000);
        end
        dbg_addr = 5'd31;
        #1;
        chk("fill_ra", dbg_n, 32'h1F1F1F1F ^ 32'hA5000000);

        // Reset beats a simultaneous write to $ra
        reset   = 1'b1;
        wr_en   = 1'b1;
        wr_addr = 5'd31;
        wr_data = 32'h12345678;
        tick();
        reset = 1'b0;
        wr_en = 1'b0;
        rd_addr1 = 5'd8;
        #1;
        chk("rst_wr_ra", dbg_n, 32'd0);
        chk("rst_wr_r8", r1_n, 32'd0);
        wr_addr = 5'd31;
        wr_data = 32'hFFFFFFFF;
        tick();
        chk("rst_ra_hold", dbg_n, 32'd0);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
